// File: rtl/mips_ctrl_pkg.sv
// Shared types for the MIPS issue/credit controller.
// Request/response bundles, controller FSM states and the fixed core latency.
package mips_ctrl_pkg;

    typedef struct packed {
        logic [31:0] instruction;
        logic [19:0] output_reg;
    } req_t;

    typedef struct packed {
        logic [127:0] data;
        logic         fail;
        logic [7:0]   tag;
    } rsp_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    localparam int CORE_LAT = 4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mips_ctrl_fifo.sv
// Synchronous FIFO used for both the instruction and the response queue.
// Push while full is accepted only when a pop happens in the same cycle.
module mips_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_issue_ctrl.sv
// Issue/credit controller in front of the 4-stage MIPS core.
// Optional saturating statistics counters: define MIPS_STATS_EN.
module mips_issue_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int RQ_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_instruction,
    input  logic [19:0]  req_output_reg,
    input  logic         flush,
    output logic         flush_done,
    output logic         core_in_valid,
    output logic [31:0]  core_instruction,
    output logic [19:0]  core_output_reg,
    input  logic         core_out_valid,
    input  logic [127:0] core_out,
    input  logic         core_fail,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_fail,
    output logic [7:0]   rsp_tag,
    output logic         err_overflow,
    output logic [15:0]  stat_issued,
    output logic [15:0]  stat_failed
);

    localparam int IQW = $clog2(IQ_DEPTH);
    localparam int RQW = $clog2(RQ_DEPTH);
    localparam logic [RQW+1:0] RQ_LIM = (RQW+2)'(RQ_DEPTH);

    ctrl_state_t     state;
    ctrl_state_t     state_nxt;

    req_t            iq_wdata;
    req_t            iq_rdata;
    logic            iq_push;
    logic            iq_full;
    logic            iq_empty;
    logic [IQW:0]    iq_count;

    rsp_t            rq_wdata;
    rsp_t            rq_rdata;
    logic            rq_push;
    logic            rq_pop;
    logic            rq_full;
    logic            rq_empty;
    logic [RQW:0]    rq_count;

    logic [RQW:0]    inflight;
    logic [RQW+1:0]  occupancy;
    logic [7:0]      rsp_cnt;
    logic            issue;
    logic            ovf;
    logic            ret_dec;
    logic            drained;

    assign iq_wdata = '{instruction: req_instruction,
                        output_reg:  req_output_reg};
    assign iq_push  = req_valid && req_ready;

    mips_ctrl_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (iq_push),
        .wdata (iq_wdata),
        .pop   (issue),
        .rdata (iq_rdata),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count)
    );

    // Credit: every issued instruction owns a response-queue slot.
    assign occupancy = {1'b0, inflight} + {1'b0, rq_count};
    assign issue     = !iq_empty && (occupancy < RQ_LIM);

    assign rq_pop   = !rq_empty && rsp_ready;
    assign ovf      = core_out_valid &&
                      ((rq_full && !rq_pop) || (inflight == '0));
    assign rq_push  = core_out_valid && !ovf;
    assign ret_dec  = core_out_valid && (inflight != '0);
    assign rq_wdata = '{data: core_out,
                        fail: core_fail,
                        tag:  rsp_cnt};

    mips_ctrl_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rq_push),
        .wdata (rq_wdata),
        .pop   (rq_pop),
        .rdata (rq_rdata),
        .full  (rq_full),
        .empty (rq_empty),
        .count (rq_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({issue, ret_dec})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_cnt      <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (rq_push) begin
                rsp_cnt <= rsp_cnt + 8'd1;
            end
            if (ovf) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in_valid    <= 1'b0;
            core_instruction <= '0;
            core_output_reg  <= '0;
        end else begin
            core_in_valid    <= issue;
            core_instruction <= issue ? iq_rdata.instruction : '0;
            core_output_reg  <= issue ? iq_rdata.output_reg : '0;
        end
    end

    assign drained = (iq_count == '0) && (inflight == '0) && rq_empty;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (flush) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign req_ready  = (state == RUN) && !iq_full;
    assign flush_done = (state == DONE);

    assign rsp_valid = !rq_empty;
    assign rsp_data  = rq_empty ? '0 : rq_rdata.data;
    assign rsp_fail  = !rq_empty && rq_rdata.fail;
    assign rsp_tag   = rq_empty ? '0 : rq_rdata.tag;

`ifdef MIPS_STATS_EN
    logic [15:0] issued_q;
    logic [15:0] failed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            failed_q <= '0;
        end else begin
            if (issue) begin
                issued_q <= sat_inc(issued_q);
            end
            if (rq_push && core_fail) begin
                failed_q <= sat_inc(failed_q);
            end
        end
    end

    assign stat_issued = issued_q;
    assign stat_failed = failed_q;
`else
    assign stat_issued = '0;
    assign stat_failed = '0;
`endif

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// Directed bench for mips_issue_ctrl with a 4-cycle behavioural core.
// Checks latency, credit back-pressure, tags, flush/drain and overflow.
module tb_mips_issue_ctrl;

`ifdef MIPS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_instruction = '0;
    logic [19:0]  req_output_reg = '0;
    logic         flush = 1'b0;
    logic         flush_done;
    logic         core_in_valid;
    logic [31:0]  core_instruction;
    logic [19:0]  core_output_reg;
    logic         core_out_valid;
    logic [127:0] core_out;
    logic         core_fail;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_fail;
    logic [7:0]   rsp_tag;
    logic         err_overflow;
    logic [15:0]  stat_issued;
    logic [15:0]  stat_failed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_issue_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_instruction  (req_instruction),
        .req_output_reg   (req_output_reg),
        .flush            (flush),
        .flush_done       (flush_done),
        .core_in_valid    (core_in_valid),
        .core_instruction (core_instruction),
        .core_output_reg  (core_output_reg),
        .core_out_valid   (core_out_valid),
        .core_out         (core_out),
        .core_fail        (core_fail),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_fail         (rsp_fail),
        .rsp_tag          (rsp_tag),
        .err_overflow     (err_overflow),
        .stat_issued      (stat_issued),
        .stat_failed      (stat_failed)
    );

    function automatic logic [127:0] core_res(input logic [31:0] i,
                                              input logic [19:0] o);
        if (i[31:26] == 6'h3f) return '0;
        return {i, ~i, {12'h0, o}, i + 32'd1};
    endfunction

    // Behavioural core: fixed 4-cycle pipeline, plus a forced return.
    logic [3:0]       pv;
    logic [3:0][31:0] pi;
    logic [3:0][19:0] po;
    logic             force_ov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pi <= '0;
            po <= '0;
        end else begin
            pv <= {pv[2:0], core_in_valid};
            pi <= {pi[2:0], core_instruction};
            po <= {po[2:0], core_output_reg};
        end
    end

    assign core_out_valid = pv[3] | force_ov;
    assign core_out  = pv[3] ? core_res(pi[3], po[3]) : '0;
    assign core_fail = pv[3] && (pi[3][31:26] == 6'h3f);

    logic [136:0] rsp_log[$];
    logic [51:0]  exp_q[$];
    int civ_n;
    int civ_run;
    int civ_max;

    always @(posedge clk) begin
        if (!rst_n) begin
            rsp_log.delete();
            civ_n   = 0;
            civ_run = 0;
            civ_max = 0;
        end else begin
            if (rsp_valid && rsp_ready)
                rsp_log.push_back({rsp_tag, rsp_fail, rsp_data});
            if (core_in_valid) begin
                civ_n++;
                civ_run++;
                if (civ_run > civ_max) civ_max = civ_run;
            end else begin
                civ_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        force_ov  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [19:0] o,
                         output bit ok);
        ok = 1'b0;
        req_valid       = 1'b1;
        req_instruction = i;
        req_output_reg  = o;
        for (int k = 0; k < 50; k++) begin
            if (req_ready) begin
                exp_q.push_back({i, o});
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (rsp_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [31:0] addi(input int k);
        return {6'b001000, 5'd1, 5'd2, 16'(k * 3 + 1)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        checks++;
        if ({core_in_valid, core_instruction, core_output_reg} !== '0) begin
            errors++;
            $display("FAIL reset_core got %b/%h/%h want 0", core_in_valid,
                     core_instruction, core_output_reg);
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_fail, rsp_tag} !== '0) begin
            errors++;
            $display("FAIL reset_rsp got %b/%h/%b/%h want 0", rsp_valid,
                     rsp_data, rsp_fail, rsp_tag);
        end
        checks++;
        if ({flush_done, err_overflow, stat_issued, stat_failed} !== '0) begin
            errors++;
            $display("FAIL reset_misc got %b/%b/%h/%h want 0", flush_done,
                     err_overflow, stat_issued, stat_failed);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [31:0] ins;
        apply_reset();
        rsp_ready = 1'b1;
        ins = {6'b001000, 5'd0, 5'd1, 16'd5};
        offer(ins, 20'b10001, ok);
        checks++;
        if (core_in_valid !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL single_c1 got valid %b ok %b want 0/1",
                     core_in_valid, ok);
        end
        tick();
        checks++;
        if (core_in_valid !== 1'b1 || core_instruction !== ins ||
            core_output_reg !== 20'b10001) begin
            errors++;
            $display("FAIL single_c2 got %b/%h/%h want 1/%h/00011",
                     core_in_valid, core_instruction, core_output_reg, ins);
        end
        tick();
        checks++;
        if ({core_in_valid, core_instruction} !== '0) begin
            errors++;
            $display("FAIL single_c3 got %b/%h want 0", core_in_valid,
                     core_instruction);
        end
        repeat (3) tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c6 rsp_valid got %b want 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 8'd0 || rsp_fail !== 1'b0 ||
            rsp_data !== core_res(ins, 20'b10001)) begin
            errors++;
            $display("FAIL single_c7 got %b/%h/%b/%h want 1/00/0/%h",
                     rsp_valid, rsp_tag, rsp_fail, rsp_data,
                     core_res(ins, 20'b10001));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int acc;
        logic [136:0] want;
        apply_reset();
        rsp_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            offer(addi(k), 20'(k), ok);
            if (ok) acc++;
        end
        wait_rsp(20, ok);
        checks++;
        if (!ok || acc != 20) begin
            errors++;
            $display("FAIL b2b_count got %0d rsp %0d acc want 20",
                     rsp_log.size(), acc);
        end
        checks++;
        if (civ_n != 20 || civ_max != 20) begin
            errors++;
            $display("FAIL b2b_issue got n %0d run %0d want 20/20",
                     civ_n, civ_max);
        end
        for (int k = 0; k < 20 && k < rsp_log.size(); k++) begin
            want = {8'(k), 1'b0, core_res(exp_q[k][51:20], exp_q[k][19:0])};
            checks++;
            if (rsp_log[k] !== want) begin
                errors++;
                $display("FAIL b2b_rsp%0d got %h want %h", k, rsp_log[k],
                         want);
            end
        end
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ovf got %b want 0", err_overflow);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc;
        logic [136:0] want;
        apply_reset();
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            offer(addi(k + 40), 20'(k + 7), ok);
            if (ok) acc++;
        end
        checks++;
        if (acc != 12 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill got acc %0d ready %b want 12/0", acc,
                     req_ready);
        end
        repeat (15) tick();
        checks++;
        if (civ_n != 8 || req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
            rsp_tag !== 8'd0) begin
            errors++;
            $display("FAIL bp_hold got issued %0d ready %b valid %b tag %h want 8/0/1/00",
                     civ_n, req_ready, rsp_valid, rsp_tag);
        end
        rsp_ready = 1'b1;
        wait_rsp(12, ok);
        checks++;
        if (!ok || civ_n != 12) begin
            errors++;
            $display("FAIL bp_release got rsp %0d issued %0d want 12/12",
                     rsp_log.size(), civ_n);
        end
        for (int k = 0; k < 12 && k < rsp_log.size(); k++) begin
            want = {8'(k), 1'b0, core_res(exp_q[k][51:20], exp_q[k][19:0])};
            checks++;
            if (rsp_log[k] !== want) begin
                errors++;
                $display("FAIL bp_rsp%0d got %h want %h", k, rsp_log[k],
                         want);
            end
        end
    endtask

    task automatic test_invalid_opcode();
        bit ok;
        apply_reset();
        rsp_ready = 1'b1;
        offer({6'h3f, 26'h123}, 20'h3, ok);
        wait_rsp(1, ok);
        checks++;
        if (!ok || rsp_log[0] !== {8'd0, 1'b1, 128'd0}) begin
            errors++;
            $display("FAIL badop_rsp got ok %b %h want fail=1 data=0", ok,
                     ok ? rsp_log[0] : 137'd0);
        end
        checks++;
        if (stat_failed !== 16'(STATS) || stat_issued !== 16'(STATS)) begin
            errors++;
            $display("FAIL badop_stats got %h/%h want %h", stat_failed,
                     stat_issued, 16'(STATS));
        end
    endtask

    task automatic test_flush();
        bit ok;
        int acc;
        int last;
        int done_at;
        int pulses;
        logic rdy_after;
        logic [136:0] want;
        apply_reset();
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            offer(addi(k + 60), 20'(k), ok);
            if (ok) acc++;
        end
        repeat (10) tick();
        for (int k = 0; k < 8; k++) begin
            flush = (k == 7);
            offer(addi(k + 70), 20'(k + 3), ok);
            flush = 1'b0;
            if (ok) acc++;
        end
        checks++;
        if (acc != 11 || req_ready !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_enter got acc %0d ready %b done %b want 11/0/0",
                     acc, req_ready, flush_done);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        checks++;
        if (flush_done !== 1'b0 || req_ready !== 1'b0 ||
            rsp_log.size() != 0) begin
            errors++;
            $display("FAIL flush_hold got done %b ready %b rsp %0d want 0/0/0",
                     flush_done, req_ready, rsp_log.size());
        end
        rsp_ready = 1'b1;
        last = -1;
        done_at = -1;
        pulses = 0;
        rdy_after = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rsp_valid && rsp_ready) last = c;
            if (done_at >= 0 && c == done_at + 1) rdy_after = req_ready;
            if (flush_done) begin
                pulses++;
                done_at = c;
            end
            tick();
        end
        checks++;
        if (pulses != 1 || done_at != last + 2 || rdy_after !== 1'b1) begin
            errors++;
            $display("FAIL flush_done got pulses %0d at %0d last %0d ready %b want 1/last+2/1",
                     pulses, done_at, last, rdy_after);
        end
        checks++;
        if (rsp_log.size() != 11) begin
            errors++;
            $display("FAIL flush_count got %0d want 11", rsp_log.size());
        end
        for (int k = 0; k < 11 && k < rsp_log.size(); k++) begin
            want = {8'(k), 1'b0, core_res(exp_q[k][51:20], exp_q[k][19:0])};
            checks++;
            if (rsp_log[k] !== want) begin
                errors++;
                $display("FAIL flush_rsp%0d got %h want %h", k, rsp_log[k],
                         want);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        rsp_ready = 1'b1;
        repeat (2) tick();
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        checks++;
        if (err_overflow !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set got err %b valid %b want 1/0",
                     err_overflow, rsp_valid);
        end
        repeat (5) tick();
        offer(addi(99), 20'h5, ok);
        wait_rsp(1, ok);
        checks++;
        if (!ok || rsp_log[0] !== {8'd0, 1'b0, core_res(addi(99), 20'h5)} ||
            err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got ok %b err %b rsp %h", ok,
                     err_overflow, ok ? rsp_log[0] : 137'd0);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", err_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_invalid_opcode();
        test_flush();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
